// File: rtl/shift_pkg.sv
// Shared types for the iterative log shifter: operation and FSM state encodings.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } shift_state_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational log-shifter stage: shifts by DIST when en is set.
// Rotate support is built only when ITER_SHIFT_ROTATE_EN is defined.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  shift_op_t        op,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
    if (en) begin
      case (op)
        SH_SLL:         result = data << DIST;
        // fill is 0 for SRL, latched sign for SRA
        SH_SRL, SH_SRA: result = (data >> DIST) | ({WIDTH{fill}} << (WIDTH - DIST));
`ifdef ITER_SHIFT_ROTATE_EN
        SH_ROR:         result = (data >> DIST) | (data << (WIDTH - DIST));
`else
        SH_ROR:         result = data;
`endif
        default:        result = data;
      endcase
    end
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle logarithmic shifter resolving STEP stages per cycle with valid/ready on both sides.
// Optional rotate (op 11) when ITER_SHIFT_ROTATE_EN is defined; otherwise op 11 passes through.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [WIDTH-1:0]         req_data,
  input  logic [$clog2(WIDTH)-1:0] req_amt,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data
);

  localparam int unsigned NSTG = $clog2(WIDTH);
  localparam int unsigned NCYC = ceil_div(NSTG, STEP);
  localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  shift_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  shift_op_t        op_q, op_d;
  logic [NSTG-1:0]  amt_q, amt_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;

  logic [NSTG:0][WIDTH-1:0] stg;

  assign stg[0] = data_q;

  // Every stage sits in the chain; only those in this cycle's window may shift.
  for (genvar i = 0; i < NSTG; i++) begin : g_stage
    localparam int unsigned CYC = i / STEP;
    logic en;
    assign en = amt_q[i] && (cnt_q == CW'(CYC));
    shift_stage #(
      .WIDTH(WIDTH),
      .DIST (1 << i)
    ) u_stage (
      .data  (stg[i]),
      .en    (en),
      .op    (op_q),
      .fill  (fill_q),
      .result(stg[i+1])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    op_d        = op_q;
    amt_d       = amt_q;
    fill_d      = fill_q;
    resp_data_d = resp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          data_d  = req_data;
          op_d    = shift_op_t'(req_op);
          amt_d   = req_amt;
          fill_d  = (shift_op_t'(req_op) == SH_SRA) ? req_data[WIDTH-1] : 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        data_d = stg[NSTG];
        if (cnt_q == CW'(NCYC - 1)) begin
          resp_data_d = stg[NSTG];
          cnt_d       = '0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      op_q        <= SH_SLL;
      amt_q       <= '0;
      fill_q      <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      op_q        <= op_d;
      amt_q       <= amt_d;
      fill_q      <= fill_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Gated by rst so no request is offered while the unit is held in reset.
  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign resp_valid = (state_q == ST_DONE);
  assign resp_data  = resp_data_q;

endmodule
